// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int BIT_TIME  = 5208;
  localparam int HALF_BIT  = 2604;
  localparam int DATA_BITS = 8;
  localparam int TIMER_W   = 13;
  localparam int BITCNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BITS  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    ACK   = 3'd5
  } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for the asynchronous serial line
module sync2 (
  input  logic clk,
  input  logic Reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Both flops reset to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (Reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rx.sv
// rtl/rx.sv - UART receiver: 8 data bits LSB first, odd parity, one stop bit
module rx
  import uart_pkg::*;
#(
  parameter int BIT_TIME = uart_pkg::BIT_TIME,
  parameter int HALF_BIT = uart_pkg::HALF_BIT
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Sin,
  input  logic                 ReceiveAck,
  output logic                 Receive,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 parityErr,
  output logic                 frameErr
);

  localparam logic [TIMER_W-1:0]  BIT_LAST  = TIMER_W'(BIT_TIME - 1);
  localparam logic [TIMER_W-1:0]  HALF_LAST = TIMER_W'(HALF_BIT - 1);
  localparam logic [BITCNT_W-1:0] LAST_BIT  = BITCNT_W'(DATA_BITS - 1);

  state_t                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic [DATA_BITS-1:0]  dout_q, dout_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  sin_s;
  logic                  bit_end;

  sync2 u_sync2 (
    .clk   (clk),
    .Reset (Reset),
    .d_i   (Sin),
    .q_o   (sin_s)
  );

  assign bit_end = (timer_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  // Timer restarts at each terminal count, so after the half-bit start check
  // every later sample lands in the middle of its bit.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    dout_d   = dout_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    case (state_q)
      IDLE: begin
        timer_d  = '0;
        bitcnt_d = '0;
        if (!sin_s) state_d = START;
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = sin_s ? IDLE : BITS;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      BITS: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = {sin_s, shift_q[DATA_BITS-1:1]};
          if (bitcnt_q == LAST_BIT) state_d = PAR;
          else bitcnt_d = bitcnt_q + BITCNT_W'(1);
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      PAR: begin
        if (bit_end) begin
          timer_d = '0;
          par_d   = sin_s;
          state_d = STOP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          dout_d  = shift_q;
          perr_d  = ~(^{shift_q, par_q});
          ferr_d  = ~sin_s;
          state_d = ACK;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ACK: begin
        if (ReceiveAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Receive = 1'b0;
    if (state_q == ACK) Receive = 1'b1;
  end

  assign Dout      = dout_q;
  assign parityErr = perr_q;
  assign frameErr  = ferr_q;

endmodule

// File: tb/tb_rx.sv
// tb/tb_rx.sv - randomized self-checking bench for the UART receiver
module tb_rx;

  localparam int BT = 64;
  localparam int HB = 32;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Sin;
  logic       ReceiveAck;
  logic       Receive;
  logic [7:0] Dout;
  logic       parityErr;
  logic       frameErr;

  rx #(.BIT_TIME(BT), .HALF_BIT(HB)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Sin        (Sin),
    .ReceiveAck (ReceiveAck),
    .Receive    (Receive),
    .Dout       (Dout),
    .parityErr  (parityErr),
    .frameErr   (frameErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } ev_t;

  ev_t  ev_q[$];
  int   width_q[$];
  logic rcv_prev = 1'b0;
  int   hi_len = 0;

  always @(negedge clk) begin
    rcv_prev <= Receive;
    if (Receive === 1'b1 && rcv_prev !== 1'b1)
      ev_q.push_back('{Dout, parityErr, frameErr, cyc});
    if (Receive === 1'b1) hi_len <= hi_len + 1;
    else if (hi_len != 0) begin
      width_q.push_back(hi_len);
      hi_len <= 0;
    end
  end

  // Expected outcome of a frame from the line-level rules alone.
  function automatic ev_t model(input logic [7:0] d, input logic p, input logic s);
    ev_t r;
    r.d  = d;
    r.pe = ($countones({d, p}) % 2) == 0;
    r.fe = (s == 1'b0);
    r.at = 0;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      Sin = f[i];
      tick(BT);
    end
    Sin = 1'b1;
  endtask

  task automatic wait_ev(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (ev_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = (ev_q.size() >= n);
  endtask

  task automatic ack_pulse();
    ReceiveAck = 1'b1;
    tick(1);
    ReceiveAck = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Sin = 1'b1;
    ReceiveAck = 1'b0;
    tick(3);
    checks++; if (Receive !== 1'b0) begin errors++; $display("FAIL reset_receive: got %b expected 0", Receive); end
    checks++; if (Dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", Dout); end
    checks++; if (parityErr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parityErr); end
    checks++; if (frameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frameErr); end
    Reset = 1'b0;
    tick(4);
    checks++; if (Receive !== 1'b0) begin errors++; $display("FAIL idle_receive: got %b expected 0", Receive); end
  endtask

  task automatic test_directed();
    logic [7:0] td[3] = '{8'h41, 8'hFF, 8'h00};
    logic       tp[3] = '{1'b1, 1'b0, 1'b1};
    logic       ts[3] = '{1'b1, 1'b1, 1'b0};
    ev_t exp;
    bit  ok;
    int  start, lat;
    for (int i = 0; i < 3; i++) begin
      ev_q.delete();
      exp = model(td[i], tp[i], ts[i]);
      start = cyc;
      send_frame(td[i], tp[i], ts[i]);
      wait_ev(1, 200, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL dir%0d_timeout: got no Receive expected one", i);
      end else begin
        lat = ev_q[0].at - start;
        if (lat < BT * 21 / 2 || lat > BT * 21 / 2 + 8) begin
          errors++; $display("FAIL dir%0d_latency: got %0d expected %0d..%0d", i, lat, BT * 21 / 2, BT * 21 / 2 + 8);
        end
        checks++; if (ev_q[0].d !== exp.d) begin errors++; $display("FAIL dir%0d_dout: got %h expected %h", i, ev_q[0].d, exp.d); end
        checks++; if (ev_q[0].pe !== exp.pe) begin errors++; $display("FAIL dir%0d_perr: got %b expected %b", i, ev_q[0].pe, exp.pe); end
        checks++; if (ev_q[0].fe !== exp.fe) begin errors++; $display("FAIL dir%0d_ferr: got %b expected %b", i, ev_q[0].fe, exp.fe); end
      end
      checks++; if (Receive !== 1'b1) begin errors++; $display("FAIL dir%0d_held: got %b expected 1", i, Receive); end
      ack_pulse();
      tick(2);
      checks++; if (Receive !== 1'b0) begin errors++; $display("FAIL dir%0d_acked: got %b expected 0", i, Receive); end
      checks++; if (Dout !== exp.d) begin errors++; $display("FAIL dir%0d_hold: got %h expected %h", i, Dout, exp.d); end
      tick(BT);
    end
  endtask

  task automatic test_false_start();
    bit ok;
    ev_q.delete();
    Sin = 1'b0;
    tick(HB / 2);
    Sin = 1'b1;
    tick(12 * BT);
    checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL false_start_events: got %0d expected 0", ev_q.size()); end
    send_frame(8'h96, ~^8'h96, 1'b1);
    wait_ev(1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL false_start_recover: got no Receive expected one"); end
    else if (ev_q[0].d !== 8'h96) begin errors++; $display("FAIL false_start_recover: got %h expected 96", ev_q[0].d); end
    ack_pulse();
    tick(BT);
  endtask

  task automatic test_reset_midframe();
    logic [10:0] f;
    bit ok;
    ev_q.delete();
    f = {1'b1, ~^8'hA5, 8'hA5, 1'b0};
    for (int i = 0; i < 5; i++) begin
      Sin = f[i];
      tick(BT);
    end
    Sin = f[5];
    tick(BT / 2);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    Sin = 1'b1;
    tick(12 * BT);
    checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL abort_events: got %0d expected 0", ev_q.size()); end
    checks++; if (Dout !== 8'h00) begin errors++; $display("FAIL abort_dout: got %h expected 00", Dout); end
    send_frame(8'h3C, ~^8'h3C, 1'b1);
    wait_ev(1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_next: got no Receive expected one"); end
    else if (ev_q[0].d !== 8'h3C || ev_q[0].pe !== 1'b0) begin
      errors++; $display("FAIL abort_next: got %h/%b expected 3c/0", ev_q[0].d, ev_q[0].pe);
    end
    ack_pulse();
    tick(BT);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic p, s;
    ev_t exp;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ^d : ~^d;
      s = ($urandom_range(0, 4) != 0);
      exp = model(d, p, s);
      ev_q.delete();
      send_frame(d, p, s);
      tick($urandom_range(1, BT));
      wait_ev(1, 100, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand%0d_timeout: got no Receive expected one", i);
      end else if (ev_q[0].d !== exp.d || ev_q[0].pe !== exp.pe || ev_q[0].fe !== exp.fe) begin
        errors++;
        $display("FAIL rand%0d: got %h/%b/%b expected %h/%b/%b", i, ev_q[0].d, ev_q[0].pe, ev_q[0].fe, exp.d, exp.pe, exp.fe);
      end
      ack_pulse();
      tick(4);
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    tmo = 1'b0;
    ev_q.delete();
    fork
      begin
        send_frame(8'h55, ~^8'h55, 1'b1);
        send_frame(8'hAA, ~^8'hAA, 1'b1);
      end
      begin
        for (int n = 0; n < 2; n++) begin
          int k;
          k = 0;
          while (Receive !== 1'b1 && k < 2000) begin
            tick(1);
            k++;
          end
          if (Receive !== 1'b1) tmo = 1'b1;
          else begin
            tick(10);
            ack_pulse();
          end
        end
      end
    join
    tick(2 * BT);
    checks++; if (tmo) begin errors++; $display("FAIL b2b_timeout: got timeout expected two Receives"); end
    checks++; if (ev_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", ev_q.size()); end
    else begin
      checks++; if (ev_q[0].d !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h expected 55", ev_q[0].d); end
      checks++; if (ev_q[1].d !== 8'hAA) begin errors++; $display("FAIL b2b_second: got %h expected aa", ev_q[1].d); end
    end
  endtask

  task automatic test_ack_held();
    logic [7:0] d[3];
    ev_q.delete();
    width_q.delete();
    ReceiveAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'($urandom_range(0, 255));
      send_frame(d[i], ~^d[i], 1'b1);
    end
    tick(BT);
    ReceiveAck = 1'b0;
    checks++;
    if (ev_q.size() != 3 || width_q.size() != 3) begin
      errors++; $display("FAIL held_count: got %0d/%0d expected 3/3", ev_q.size(), width_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (ev_q[i].d !== d[i]) begin errors++; $display("FAIL held_data%0d: got %h expected %h", i, ev_q[i].d, d[i]); end
        checks++; if (width_q[i] != 1) begin errors++; $display("FAIL held_width%0d: got %0d expected 1", i, width_q[i]); end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Sin = 1'b1;
    ReceiveAck = 1'b0;
    test_reset();
    test_directed();
    test_false_start();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    test_ack_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
